// File: rtl/i2s_master_transmitter.sv
// I2S master transmitter: generates bclk/lrck from clk and shifts out stereo
// samples MSB-first, one bclk after each lrck edge. A 1-deep holding buffer
// takes pairs over valid/ready; a shadow pair is loaded only at frame start.
module i2s_master_transmitter #(
  parameter int WORD_LENGTH = 16,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_DIV    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] sample_L,
  input  logic [WORD_LENGTH-1:0] sample_R,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   bclk,
  output logic                   lrck,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int HALF  = BCLK_DIV / 2;
  localparam int DW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int CW    = $clog2(FRAME);

  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] SLOT     = CW'(SLOT_BITS);

  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic                   bclk_q, bclk_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;
  logic                   hold_full_q, hold_full_d;
  logic [WORD_LENGTH-1:0] hold_l_q, hold_l_d;
  logic [WORD_LENGTH-1:0] hold_r_q, hold_r_d;
  logic [WORD_LENGTH-1:0] shadow_l_q, shadow_l_d;
  logic [WORD_LENGTH-1:0] shadow_r_q, shadow_r_d;

  logic                   div_wrap;
  logic                   fall;
  logic                   accept;
  logic [CW-1:0]          bit_next;
  logic                   lrck_next;
  logic [CW-1:0]          pos;
  logic [WORD_LENGTH-1:0] word;
  logic                   bit_val;

  // Bit position and data bit that the next bclk fall will present.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    fall      = div_wrap & bclk_q;
    accept    = sample_valid & ~hold_full_q;
    bit_next  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    lrck_next = (bit_next >= SLOT);
    pos       = lrck_next ? bit_next - SLOT : bit_next;
    word      = lrck_next ? shadow_r_q : shadow_l_q;
    bit_val   = 1'b0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (pos == CW'(WORD_LENGTH - i)) bit_val = word[i];
    end
  end

  // Next-state: divider, serializer, holding buffer and frame-start transfer.
  always_comb begin
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d        = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;

    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = sample_L;
      hold_r_d    = sample_R;
    end

    if (fall) begin
      bit_cnt_d = bit_next;
      lrck_d    = lrck_next;
      sdata_d   = bit_val;
      if (bit_next == '0) begin
        frame_start_d = 1'b1;
        if (hold_full_q) begin
          shadow_l_d  = hold_l_q;
          shadow_r_d  = hold_r_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // Pair arriving exactly at frame start skips the holding buffer.
          shadow_l_d  = sample_L;
          shadow_r_d  = sample_R;
          hold_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards any held pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign bclk         = bclk_q;
  assign lrck         = lrck_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule
